// File: rtl/gravity_sequencer_pkg.sv
// rtl/gravity_sequencer_pkg.sv - shared gravity sequencer types and defaults
package gravity_sequencer_pkg;

    localparam int DEF_LEVEL_W     = 4;
    localparam int DEF_BASE_PERIOD = 15;
    localparam int DEF_LOCK_TICKS  = 2;
    localparam int DEF_CNT_W       = 4;

    typedef enum logic [1:0] {
        ST_COUNT     = 2'd0,
        ST_DROP_REQ  = 2'd1,
        ST_LOCK_WAIT = 2'd2,
        ST_LOCK_REQ  = 2'd3
    } seq_state_t;

endpackage

// File: rtl/gravity_period.sv
// rtl/gravity_period.sv - level to drop period, saturating at one tick
module gravity_period
    import gravity_sequencer_pkg::*;
#(
    parameter int LEVEL_W     = DEF_LEVEL_W,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int BASE_PERIOD = DEF_BASE_PERIOD
)(
    input  logic [LEVEL_W-1:0] level,
    output logic [CNT_W-1:0]   period
);

    // Faster levels shorten the period; never let it reach zero
    always_comb begin
        if (32'(level) < 32'(BASE_PERIOD)) begin
            period = CNT_W'(32'(BASE_PERIOD) - 32'(level));
        end else begin
            period = CNT_W'(1);
        end
    end

endmodule

// File: rtl/gravity_sequencer.sv
// rtl/gravity_sequencer.sv - turns game ticks into drop/lock requests
module gravity_sequencer
    import gravity_sequencer_pkg::*;
#(
    parameter int LEVEL_W     = DEF_LEVEL_W,
    parameter int BASE_PERIOD = DEF_BASE_PERIOD,
    parameter int LOCK_TICKS  = DEF_LOCK_TICKS,
    parameter int CNT_W       = DEF_CNT_W
)(
    input  logic               clk,
    input  logic               rst,
    input  logic               pause,
    input  logic               tick,
    input  logic [LEVEL_W-1:0] level,
    input  logic               soft_drop,
    input  logic               landed,
    output logic               drop_req,
    input  logic               drop_ack,
    output logic               lock_req,
    input  logic               lock_ack,
    output logic               overrun
);

    seq_state_t       state, state_d;
    logic [CNT_W-1:0] tick_cnt, tick_cnt_d;
    logic [CNT_W-1:0] lock_cnt, lock_cnt_d;
    logic             pending, pending_d;
    logic             drop_req_d, lock_req_d, overrun_d;
    logic [CNT_W-1:0] period;
    logic [CNT_W:0]   tick_next;
    logic [CNT_W:0]   lock_next;
    logic             drop_due;
    logic             lock_due;

    gravity_period #(
        .LEVEL_W     (LEVEL_W),
        .CNT_W       (CNT_W),
        .BASE_PERIOD (BASE_PERIOD)
    ) u_period (
        .level  (level),
        .period (period)
    );

    // >= rather than == so a mid-count level increase fires on the next tick
    assign tick_next = {1'b0, tick_cnt} + (CNT_W+1)'(1);
    assign lock_next = {1'b0, lock_cnt} + (CNT_W+1)'(1);
    assign drop_due  = tick && (soft_drop || (tick_next >= {1'b0, period}));
    assign lock_due  = tick && (lock_next == (CNT_W+1)'(LOCK_TICKS));

    // State and counter registers; pause freezes everything except reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_COUNT;
            tick_cnt <= '0;
            lock_cnt <= '0;
            pending  <= 1'b0;
            drop_req <= 1'b0;
            lock_req <= 1'b0;
            overrun  <= 1'b0;
        end else if (!pause) begin
            state    <= state_d;
            tick_cnt <= tick_cnt_d;
            lock_cnt <= lock_cnt_d;
            pending  <= pending_d;
            drop_req <= drop_req_d;
            lock_req <= lock_req_d;
            overrun  <= overrun_d;
        end
    end

    // Next state, tick/lock counting and the deferred-drop flag
    always_comb begin
        state_d    = state;
        tick_cnt_d = tick_cnt;
        lock_cnt_d = lock_cnt;
        pending_d  = pending;
        case (state)
            ST_COUNT: begin
                if (pending) begin
                    pending_d = 1'b0;
                    state_d   = ST_DROP_REQ;
                end else if (landed) begin
                    lock_cnt_d = '0;
                    tick_cnt_d = '0;
                    state_d    = ST_LOCK_WAIT;
                end else if (drop_due) begin
                    tick_cnt_d = '0;
                    state_d    = ST_DROP_REQ;
                end else if (tick) begin
                    tick_cnt_d = tick_next[CNT_W-1:0];
                end
            end
            ST_DROP_REQ: begin
                if (drop_due) begin
                    tick_cnt_d = '0;
                    pending_d  = 1'b1;
                end else if (tick) begin
                    tick_cnt_d = tick_next[CNT_W-1:0];
                end
                if (drop_ack) begin
                    state_d = ST_COUNT;
                end
            end
            ST_LOCK_WAIT: begin
                if (!landed) begin
                    tick_cnt_d = '0;
                    state_d    = ST_COUNT;
                end else if (tick) begin
                    lock_cnt_d = lock_next[CNT_W-1:0];
                    if (lock_due) begin
                        state_d = ST_LOCK_REQ;
                    end
                end
            end
            ST_LOCK_REQ: begin
                if (lock_ack) begin
                    tick_cnt_d = '0;
                    lock_cnt_d = '0;
                    pending_d  = 1'b0;
                    state_d    = ST_COUNT;
                end
            end
            default: begin
                state_d = ST_COUNT;
            end
        endcase
    end

    // Requests follow the next state, so they can never overlap
    always_comb begin
        drop_req_d = (state_d == ST_DROP_REQ);
        lock_req_d = (state_d == ST_LOCK_REQ);
        overrun_d  = (state == ST_DROP_REQ) && drop_due && pending;
    end

endmodule

// File: doc/gravity_sequencer.md
Name: gravity_sequencer

Overview:
- Consumer of the 1-cycle game tick pulse. Converts ticks into piece-drop and piece-lock requests for the game state machine.
- Drop interval is level-dependent. Soft drop forces a drop on every tick.
- Requests use a level req/ack handshake. Sits between the game clock divider and the board/piece controller.

Parameters:
- LEVEL_W, 4, width of level input
- BASE_PERIOD, 15, ticks per drop at level 0
- LOCK_TICKS, 2, ticks a landed piece rests before lock is requested
- CNT_W, 4, width of tick/lock counters (must hold BASE_PERIOD)

Ports:
- clk  in  1  system clock
- rst  in  1  reset: synchronous, active-high
- pause  in  1  freeze all state; ticks and acks ignored
- tick  in  1  one-cycle game tick pulse
- level  in  LEVEL_W  current game level
- soft_drop  in  1  player holding down
- landed  in  1  piece resting on stack/floor (level signal)
- drop_req  out  1  request: move piece down one row
- drop_ack  in  1  game logic accepted drop
- lock_req  out  1  request: lock piece into board
- lock_ack  in  1  game logic accepted lock
- overrun  out  1  one-cycle pulse: a drop was lost while a request was outstanding

Behaviour:
- Reset:
  - rst has priority over pause.
  - state=COUNT; tick_cnt=0; lock_cnt=0; pending=0; drop_req=0; lock_req=0; overrun=0.
- Period calculation:
  - period = BASE_PERIOD - level if level < BASE_PERIOD, else 1 (saturate, never 0).
  - Evaluated combinationally every cycle.
- Pause:
  - When pause=1 and rst=0, every register holds its value.
  - drop_req/lock_req stay at their current level.
  - tick, drop_ack and lock_ack are ignored.
- Outputs: all registered. overrun defaults to 0 each cycle.
- State COUNT:
  - If pending=1: pending<=0, drop_req<=1, go DROP_REQ (next cycle). Takes priority over landed.
  - Else if landed=1: lock_cnt<=0, tick_cnt<=0, go LOCK_WAIT.
  - Else on tick:
    - If soft_drop=1 or tick_cnt+1 >= period: tick_cnt<=0, drop_req<=1, go DROP_REQ.
    - Otherwise tick_cnt<=tick_cnt+1.
    - The >= compare handles a level increase mid-count: the drop fires on the next tick.
- State DROP_REQ:
  - drop_req held high until drop_ack=1 is sampled. Next cycle: drop_req=0, state COUNT.
  - Ticks while waiting still count. Reaching the period (or a tick with soft_drop) sets tick_cnt<=0 and pending<=1.
  - If pending was already 1 at that point, overrun<=1 for one cycle and pending stays 1.
  - If tick and drop_ack arrive in the same cycle, both apply.
  - After ack with pending=1: drop_req is low for exactly one cycle (COUNT), then re-asserts.
- State LOCK_WAIT:
  - If landed=0 (piece slid off): tick_cnt<=0, go COUNT. Checked before tick.
  - Else on tick: lock_cnt<=lock_cnt+1.
  - When lock_cnt+1 == LOCK_TICKS: lock_req<=1, go LOCK_REQ.
  - soft_drop is ignored in this state.
- State LOCK_REQ:
  - lock_req held until lock_ack sampled. Next cycle: lock_req=0, tick_cnt=0, lock_cnt=0, pending=0, state COUNT.
  - Ticks are ignored in this state.
- Invariants:
  - drop_req and lock_req are never high simultaneously.
  - An ack arriving without its req asserted is ignored.
- Reset mid-handshake: requests drop the next cycle and are not replayed.

Decomposition:
- Shared game package holds:
  - state encoding (COUNT, DROP_REQ, LOCK_WAIT, LOCK_REQ)
  - BASE_PERIOD and LOCK_TICKS defaults
  - LEVEL_W
- Optional sub-module gravity_period: combinational level -> period saturating subtract. Otherwise a single module.

Test Plan:
- Reset/period: level=0, 15 ticks -> drop_req rises the cycle after the 15th tick. drop_ack one cycle later -> drop_req low next cycle.
- Level saturation: level=15, each tick -> one drop_req per tick. Level changed 0->10 with tick_cnt=7 -> drop on the next tick.
- Soft drop: level=0, soft_drop=1 -> drop_req after the first tick. Hold ack off for 2 periods (30 ticks) -> pending set after 15 ticks, overrun pulses once at tick 30. After ack, drop_req low one cycle then high again.
- Lock: landed=1 in COUNT -> LOCK_WAIT. 2 ticks -> lock_req; lock_ack -> lock_req low, counters 0. Repeat with landed dropping after 1 tick -> back to COUNT, no lock_req.
- Pause: pause=1 while drop_req=1 -> drop_req stays 1, acks/ticks ignored for 10 cycles. Release -> ack completes normally. Also assert rst while pause=1 -> all outputs 0 next cycle.
- Simultaneous: tick and drop_ack in the same cycle with tick_cnt=period-1 -> drop_req falls, pending=1, drop_req re-asserts 2 cycles after the ack.
